// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: I2C slave read-path sequencer driving the SDA mux select and TX strobes.
// Define I2C_TIMEOUT_EN to abort to IDLE after TIMEOUT_CYCLES clocks without bus activity.
module i2c_slave_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'b1111000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       scl_rising,
  input  logic       scl_falling,
  input  logic       sda_in,
  input  logic [7:0] rx_data,
  input  logic       tx_empty,
  output logic [1:0] sda_mode,
  output logic       rx_enable,
  output logic       load_data,
  output logic       tx_enable,
  output logic       read_enable,
  output logic       busy,
  output logic       tx_underrun
);
  typedef enum logic [3:0] {
    IDLE, ADDR, CHK_ADDR, ACK_ADDR, NACK, LOAD, TX, REL_ACK, CHK_ACK, WAIT_STOP
  } state_t;
  state_t state, next_state;
  logic [3:0] cnt;
  logic inc, tmo;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
`ifdef I2C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic bus_ev;
  assign bus_ev = scl_rising | scl_falling | start_found | stop_found;
  assign tmo = state != IDLE && !bus_ev && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) tmo_cnt <= '0;
    else tmo_cnt <= (bus_ev || state == IDLE) ? '0 : tmo_cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  assign inc = ((state == ADDR || state == REL_ACK) && scl_rising) || (state == TX && scl_falling);
  always_comb begin
    next_state = state;
    case (state)
      ADDR:     if (scl_falling && cnt == 4'd8) next_state = CHK_ADDR;
      CHK_ADDR: next_state = rx_data[7:1] != SLAVE_ADDR ? WAIT_STOP : rx_data[0] ? ACK_ADDR : NACK;
      ACK_ADDR: if (scl_falling) next_state = LOAD;
      NACK:     if (scl_falling) next_state = WAIT_STOP;
      LOAD:     next_state = TX;
      TX:       if (scl_falling && cnt == 4'd7) next_state = REL_ACK;
      REL_ACK:  if (scl_rising) next_state = sda_in ? WAIT_STOP : CHK_ACK;
      CHK_ACK:  if (scl_falling) next_state = LOAD;
      default:  next_state = state;
    endcase
    if (tmo || stop_found) next_state = IDLE;
    if (start_found) next_state = ADDR;
  end
  // Outputs are decoded from next_state so they are registered yet track the state they describe.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sda_mode    <= 2'b00;
      rx_enable   <= 1'b0;
      load_data   <= 1'b0;
      tx_enable   <= 1'b0;
      read_enable <= 1'b0;
      busy        <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= (next_state != state || start_found) ? 4'd0 : cnt + {3'b000, inc};
      sda_mode    <= next_state == ACK_ADDR ? 2'b01 : next_state == NACK ? 2'b10 :
                     next_state == TX ? 2'b11 : 2'b00;
      rx_enable   <= next_state == ADDR;
      load_data   <= next_state == LOAD;
      tx_enable   <= state == TX && next_state == TX && scl_falling;
      read_enable <= next_state == LOAD && !tx_empty;
      busy        <= next_state != IDLE;
      tx_underrun <= tx_underrun | (next_state == LOAD && tx_empty);
    end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: transaction-level model of the slave read path checked against i2c_slave_ctrl.
module tb_i2c_slave_ctrl;
  localparam logic [6:0] SLAVE = 7'h78;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [3:0] ev = 4'b0000;
  logic sda_in = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic tx_empty = 1'b0;
  logic [1:0] sda_mode;
  logic rx_enable, load_data, tx_enable, read_enable, busy, tx_underrun;
  int total = 0, passed = 0;
  int n_load = 0, n_read = 0, n_txen = 0;
  logic chk = 1'b0;
  logic [1:0] exp_mode = 2'b00;
  logic exp_rxen = 1'b0;
  logic e_underrun = 1'b0;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLAVE_ADDR(SLAVE), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst), .start_found(ev[2]), .stop_found(ev[3]),
    .scl_rising(ev[0]), .scl_falling(ev[1]), .sda_in(sda_in), .rx_data(rx_data),
    .tx_empty(tx_empty), .sda_mode(sda_mode), .rx_enable(rx_enable), .load_data(load_data),
    .tx_enable(tx_enable), .read_enable(read_enable), .busy(busy), .tx_underrun(tx_underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Strobe counting and mid-SCL-high sampling of what the master would see.
  always @(negedge clk) if (n_rst) begin
    if (load_data) n_load++;
    if (read_enable) begin
      n_read++;
      check("read_with_load", load_data, 1);
    end
    if (tx_enable) n_txen++;
    if (chk) begin
      check("sda_mode", sda_mode, exp_mode);
      check("rx_enable", rx_enable, exp_rxen);
      check("busy_in_txn", busy, 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int k);
    @(posedge clk); #1 ev[k] = 1'b1;
    @(posedge clk); #1 ev[k] = 1'b0;
  endtask

  task automatic clock_bit(input logic sda, input logic [1:0] mode, input logic rxen);
    sda_in = sda; exp_mode = mode; exp_rxen = rxen;
    cyc(1);
    pulse(0);
    chk = 1'b1;
    @(posedge clk); #1 chk = 1'b0;
    pulse(1);
  endtask

  task automatic do_start();
    pulse(0); pulse(2); pulse(1);
  endtask

  task automatic do_stop();
    pulse(0); pulse(3);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_mode", sda_mode, 0);
  endtask

  task automatic addr_phase(input logic [7:0] addr, input logic [1:0] ack_mode);
    do_start();
    rx_data = addr;
    for (int i = 0; i < 8; i++) clock_bit(addr[7-i], 2'b00, 1'b1);
    clock_bit(1'b1, ack_mode, 1'b0);
  endtask

  // Master reads up to nbytes; bit b of nack_mask is the master's answer to byte b,
  // bit b of empty_mask is the FIFO state when byte b is loaded.
  task automatic txn(input logic [7:0] addr, input int nbytes, input logic [7:0] nack_mask,
                     input logic [7:0] empty_mask, input bit stop, input bit pin);
    bit hit;
    int e_load, e_read, e_txen;
    hit = addr[7:1] == SLAVE;
    e_load = 0; e_read = 0; e_txen = 0;
    n_load = 0; n_read = 0; n_txen = 0;
    tx_empty = empty_mask[0];
    addr_phase(addr, hit ? (addr[0] ? 2'b01 : 2'b10) : 2'b00);
    if (pin) begin
      @(negedge clk);
      check("load_pulse", load_data, 1);
      check("mode_during_load", sda_mode, 0);
      @(negedge clk);
      check("first_bit_mode", sda_mode, 3);
      check("load_single", load_data, 0);
    end
    if (hit && addr[0]) begin
      for (int b = 0; b < nbytes; b++) begin
        e_load++;
        if (!empty_mask[b]) e_read++;
        if (empty_mask[b]) e_underrun = 1'b1;
        for (int i = 0; i < 8; i++) clock_bit(1'b1, 2'b11, 1'b0);
        e_txen += 7;
        if (b + 1 < nbytes) tx_empty = empty_mask[b+1];
        clock_bit(nack_mask[b], 2'b00, 1'b0);
        if (nack_mask[b]) break;
      end
    end else if (hit) clock_bit(1'b1, 2'b00, 1'b0);
    cyc(2);
    @(negedge clk);
    check("wait_stop_busy", busy, 1);
    check("wait_stop_mode", sda_mode, 0);
    check("load_count", n_load, e_load);
    check("read_count", n_read, e_read);
    check("txen_count", n_txen, e_txen);
    check("underrun", tx_underrun, e_underrun);
    if (stop) do_stop();
  endtask

  initial begin
    cyc(2);
    check("reset_outputs", {sda_mode, rx_enable, load_data, tx_enable, read_enable, busy, tx_underrun}, 0);
    @(negedge clk) n_rst = 1'b1;
    cyc(2);

    addr_phase(8'hF1, 2'b01);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 2'b11, 1'b0);
    check("tx_mode_before_reset", sda_mode, 3);
    #2 n_rst = 1'b0;
    #1;
    check("reset_mid_tx_mode", sda_mode, 0);
    check("reset_mid_tx_all", {sda_mode, rx_enable, load_data, tx_enable, read_enable, busy, tx_underrun}, 0);
    @(negedge clk) n_rst = 1'b1;
    e_underrun = 1'b0;
    cyc(2);
    check("after_reset_busy", busy, 0);

    txn(8'hF1, 1, 8'h01, 8'h00, 1'b1, 1'b1);
    check("one_byte_loads", n_load, 1);
    check("one_byte_reads", n_read, 1);
    check("one_byte_txen", n_txen, 7);

    txn(8'hF0, 1, 8'h01, 8'h00, 1'b1, 1'b0);
    check("write_no_load", n_load, 0);

    txn(8'hA1, 1, 8'h01, 8'h00, 1'b0, 1'b0);
    check("mismatch_no_strobes", n_load + n_read + n_txen, 0);
    txn(8'hF1, 1, 8'h01, 8'h00, 1'b1, 1'b0);
    check("restart_loads", n_load, 1);

    txn(8'hF1, 2, 8'h02, 8'h02, 1'b1, 1'b0);
    check("two_byte_loads", n_load, 2);
    check("two_byte_reads", n_read, 1);
    check("two_byte_underrun", tx_underrun, 1);

    tx_empty = 1'b0;
    addr_phase(8'hF1, 2'b01);
    for (int i = 0; i < 2; i++) clock_bit(1'b1, 2'b11, 1'b0);
    cyc(20);
    @(negedge clk);
`ifdef I2C_TIMEOUT_EN
    check("timeout_busy", busy, 0);
    check("timeout_mode", sda_mode, 0);
`else
    check("stall_busy", busy, 1);
    check("stall_mode", sda_mode, 3);
`endif
    do_stop();
    check("underrun_sticky", tx_underrun, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
